key_input_pio: RTL and testbench
================================

Name: key_input_pio

Overview:
- Avalon-MM slave input PIO. It is the input-side counterpart to the Nios II LED output PIO.
- Samples DE1-SoC push-buttons (or switches), synchronizes and debounces them, and latches press edges.
- Presents the result to the Nios II through a register map laid out like the standard PIO: data, interrupt mask, edge capture.
- Drives an IRQ line to the processor.

Parameters:
- WIDTH, 4: number of input pins (4 for KEY[3:0]).
- DEBOUNCE_CYCLES, 50000: consecutive stable clock cycles needed to accept a new level (1 ms at 50 MHz). Must be >= 2.
- ACTIVE_LOW, 1: 1 means a pin level of 0 is "pressed"; internal logic is active-high after inversion.

Ports:
- clk  in  1  system clock (CLOCK_50 domain).
- reset  in  1  asynchronous, active-high reset.
- pins_in  in  WIDTH  raw asynchronous button/switch pins.
- chipselect  in  1  Avalon slave select.
- address  in  2  word address: 0 data, 1 reserved, 2 irq mask, 3 edge capture.
- read  in  1  Avalon read strobe.
- write  in  1  Avalon write strobe.
- writedata  in  32  write data.
- readdata  out  32  registered read data.
- irq  out  1  level interrupt to the processor.

Behaviour:
- Reset values (async assert, applied on the next edge after deassert):
  - readdata = 0, irq = 0, mask = 0, edge = 0, debounce counters = 0.
  - Stable state = all released (0).
  - Synchronizer flops = released level: all 1s if ACTIVE_LOW, else all 0s.
- Synchronizer: 2 flops per bit. The output is inverted when ACTIVE_LOW=1, giving sync[i] with 1 = pressed.
- Debounce, per bit, with an independent counter of width clog2(DEBOUNCE_CYCLES):
  - If sync[i] == stable[i]: counter clears to 0.
  - Else if counter == DEBOUNCE_CYCLES-1: stable[i] <= sync[i] and the counter clears.
  - Else: counter increments.
  - Net effect: stable changes after DEBOUNCE_CYCLES consecutive differing cycles. Pin-to-stable latency is 2 + DEBOUNCE_CYCLES clocks.
  - A glitch shorter than DEBOUNCE_CYCLES never changes stable.
- Edge capture:
  - edge[i] sets on the same clock edge on which stable[i] goes 0->1 (press).
  - Releases (1->0) never set edge bits.
  - Once set, an edge bit holds until cleared by software.
- Writes (chipselect & write):
  - addr 2: mask <= writedata[WIDTH-1:0].
  - addr 3: write-1-to-clear, edge[i] <= 0 wherever writedata[i] = 1.
  - addr 0 and addr 1: ignored.
  - Simultaneous set and clear of the same edge bit in one cycle: set wins, bit ends 1.
- Reads (chipselect & read):
  - Read latency is 1; readdata updates on the clock edge after the request.
  - addr 0 returns stable. addr 1 returns 0. addr 2 returns mask. addr 3 returns edge.
  - Bits [31:WIDTH] always read 0.
  - readdata holds its last value when no read is presented.
  - Reads have no side effects.
- irq = |(edge & mask), combinational from registers. It follows a mask write or edge set/clear with zero extra cycles after the register update.
- No internal waitrequest; every access completes in one cycle.
- Reset mid-debounce: counters and stable clear; a partially debounced press is discarded and no edge is produced.
- Counter must not wrap; it is held by the compare at DEBOUNCE_CYCLES-1.

Test Plan:
(Bench uses WIDTH=4, DEBOUNCE_CYCLES=8, ACTIVE_LOW=1.)
1. Reset asserted, pins_in=4'hF, then released -> irq=0; reads of addr 0, 2 and 3 all return 0x00000000 one cycle after each read.
2. pins_in=4'hD (KEY[1] pressed) held 20 cycles -> addr 0 reads 0x2 from cycle 10 after the pin change onward; addr 3 reads 0x2; irq stays 0 (mask=0). Then write 0x2 to addr 2 -> irq=1 the cycle after the write.
3. pins_in low on bit 0 for 5 cycles, then high -> addr 0 stays 0x0, addr 3 stays 0x0, irq stays 0.
4. With edge=0x2 and mask=0x2, write 0x2 to addr 3 -> addr 3 reads 0x0 and irq=0 the next cycle. Repeat with bit 0's press completing in the same cycle as a write of 0x1 to addr 3 -> edge bit 0 reads 1.
5. Press and debounce KEY[2], clear its edge, then release (pin high for 8+ cycles) -> addr 0 returns to 0x0; edge stays 0x0 (no release edge).
6. Pin low for 6 cycles, reset pulsed for 1 cycle, pin held low afterwards -> no edge before reset; after reset, a fresh 2+8-cycle debounce elapses before data reads 0x1 and edge sets.

Source files
------------

// File: rtl/key_input_pio.sv
`default_nettype none
// ============================================================================
// Module   : key_input_pio
// Brief    : Avalon-MM input PIO with per-pin synchronizer, debounce, press
//            edge capture, interrupt mask and level IRQ.
// Revision : 1.0 - initial release
// ============================================================================
module key_input_pio #(
   parameter int WIDTH           = 4,
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter bit ACTIVE_LOW      = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [WIDTH-1:0]  pins_in,
   input  logic              chipselect,
   input  logic [1:0]        address,
   input  logic              read,
   input  logic              write,
   input  logic [31:0]       writedata,
   output logic [31:0]       readdata,
   output logic              irq
);

   localparam int               c_cnt_w   = $clog2(DEBOUNCE_CYCLES);
   localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(DEBOUNCE_CYCLES - 1);
   localparam logic [WIDTH-1:0] c_release = ACTIVE_LOW ? {WIDTH{1'b1}} : {WIDTH{1'b0}};

   logic [WIDTH-1:0] r_sync1;
   logic [WIDTH-1:0] r_sync2;
   logic [WIDTH-1:0] r_stable;
   logic [WIDTH-1:0] r_edge;
   logic [WIDTH-1:0] r_mask;
   logic [WIDTH-1:0] w_sync;
   logic [WIDTH-1:0] w_done;
   logic [WIDTH-1:0] w_rise;
   logic [WIDTH-1:0] w_clear;
   logic [31:0]      w_rdata;
   logic             w_wr;
   logic             w_rd;

   // Synchronizer idles at the released pin level so reset never looks like a press.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sync1 <= c_release;
         r_sync2 <= c_release;
      end else begin
         r_sync1 <= pins_in;
         r_sync2 <= r_sync1;
      end
   end

   assign w_sync = ACTIVE_LOW ? ~r_sync2 : r_sync2;

   generate
      for (genvar i = 0; i < WIDTH; i++) begin : g_debounce
         logic [c_cnt_w-1:0] r_cnt;
         logic               w_diff;

         assign w_diff    = (w_sync[i] != r_stable[i]);
         assign w_done[i] = w_diff && (r_cnt == c_cnt_max);

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               r_cnt <= '0;
            end else if (!w_diff || w_done[i]) begin
               r_cnt <= '0;
            end else begin
               r_cnt <= r_cnt + 1'b1;
            end
         end
      end
   endgenerate

   assign w_rise  = w_done & w_sync;
   assign w_wr    = chipselect && write;
   assign w_rd    = chipselect && read;
   assign w_clear = (w_wr && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

   // A press completing in the same cycle as a clear keeps the bit set.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_stable <= '0;
         r_edge   <= '0;
         r_mask   <= '0;
      end else begin
         r_stable <= r_stable ^ w_done;
         r_edge   <= (r_edge & ~w_clear) | w_rise;
         if (w_wr && address == 2'd2) begin
            r_mask <= writedata[WIDTH-1:0];
         end
      end
   end

   always_comb begin
      w_rdata = '0;
      case (address)
         2'd0:    w_rdata[WIDTH-1:0] = r_stable;
         2'd2:    w_rdata[WIDTH-1:0] = r_mask;
         2'd3:    w_rdata[WIDTH-1:0] = r_edge;
         default: w_rdata = '0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         readdata <= '0;
      end else if (w_rd) begin
         readdata <= w_rdata;
      end
   end

   assign irq = |(r_edge & r_mask);

   generate
      if (WIDTH < 32) begin : g_unused_wdata
         logic w_unused_wdata;
         assign w_unused_wdata = |writedata[31:WIDTH];
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_key_input_pio.sv
`default_nettype none
// ============================================================================
// Module   : tb_key_input_pio
// Brief    : Randomized and directed bench for key_input_pio with a
//            cycle-level reference model of the PIO register behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module tb_key_input_pio;

   localparam int WIDTH = 4;
   localparam int DC    = 8;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  pins_in;
   logic        chipselect;
   logic [1:0]  address;
   logic        read;
   logic        write;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic        irq;

   int n_checks = 0;
   int n_err    = 0;

   // Reference model state: press levels seen through a two-stage delay,
   // count of consecutive differing samples, and the software-visible registers.
   logic [3:0]  m_d1, m_d2, m_stable, m_edge, m_mask;
   logic [31:0] m_rd;
   int          m_run [4];

   always #5 clk = ~clk;

   key_input_pio #(
      .WIDTH           (WIDTH),
      .DEBOUNCE_CYCLES (DC),
      .ACTIVE_LOW      (1'b1)
   ) u_dut (
      .clk        (clk),
      .reset      (reset),
      .pins_in    (pins_in),
      .chipselect (chipselect),
      .address    (address),
      .read       (read),
      .write      (write),
      .writedata  (writedata),
      .readdata   (readdata),
      .irq        (irq)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_d1 = '0; m_d2 = '0; m_stable = '0; m_edge = '0; m_mask = '0; m_rd = '0;
      for (int i = 0; i < 4; i++) m_run[i] = 0;
   endtask

   task automatic model_step();
      logic [3:0] lvl, rise, clr;
      if (reset) begin
         model_reset();
         return;
      end
      if (chipselect && read) begin
         case (address)
            2'd0:    m_rd = {28'd0, m_stable};
            2'd2:    m_rd = {28'd0, m_mask};
            2'd3:    m_rd = {28'd0, m_edge};
            default: m_rd = 32'd0;
         endcase
      end
      lvl  = m_d2;
      m_d2 = m_d1;
      m_d1 = ~pins_in;
      rise = '0;
      for (int i = 0; i < 4; i++) begin
         if (lvl[i] != m_stable[i]) begin
            m_run[i]++;
            if (m_run[i] == DC) begin
               m_stable[i] = lvl[i];
               m_run[i]    = 0;
               rise[i]     = lvl[i];
            end
         end else begin
            m_run[i] = 0;
         end
      end
      clr = (chipselect && write && address == 2'd3) ? writedata[3:0] : 4'd0;
      if (chipselect && write && address == 2'd2) m_mask = writedata[3:0];
      m_edge = (m_edge & ~clr) | rise;
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      check("irq", {31'd0, irq}, {31'd0, |(m_edge & m_mask)});
      check("readdata", readdata, m_rd);
   endtask

   task automatic bus(input logic cs, input logic rd, input logic wr,
                      input logic [1:0] a, input logic [31:0] d);
      chipselect = cs; read = rd; write = wr; address = a; writedata = d;
   endtask

   task automatic idle(input int n);
      bus(1'b0, 1'b0, 1'b0, 2'd0, 32'd0);
      repeat (n) tick();
   endtask

   task automatic do_read(input logic [1:0] a);
      bus(1'b1, 1'b1, 1'b0, a, 32'd0);
      tick();
      bus(1'b0, 1'b0, 1'b0, 2'd0, 32'd0);
   endtask

   task automatic do_write(input logic [1:0] a, input logic [31:0] d);
      bus(1'b1, 1'b0, 1'b1, a, d);
      tick();
      bus(1'b0, 1'b0, 1'b0, 2'd0, 32'd0);
   endtask

   initial begin
      reset   = 1'b1;
      pins_in = 4'hF;
      bus(1'b0, 1'b0, 1'b0, 2'd0, 32'd0);
      model_reset();
      repeat (3) tick();
      reset = 1'b0;

      // Reset state
      check("irq_after_reset", {31'd0, irq}, 32'd0);
      do_read(2'd0); check("rst_data", readdata, 32'h0);
      do_read(2'd2); check("rst_mask", readdata, 32'h0);
      do_read(2'd3); check("rst_edge", readdata, 32'h0);

      // KEY[1] press, then unmask
      pins_in = 4'hD;
      idle(20);
      do_read(2'd0); check("key1_data", readdata, 32'h2);
      do_read(2'd3); check("key1_edge", readdata, 32'h2);
      check("key1_irq_masked", {31'd0, irq}, 32'd0);
      do_write(2'd2, 32'h2);
      check("key1_irq_unmasked", {31'd0, irq}, 32'd1);

      // Short glitch on bit 0 is rejected
      pins_in = 4'hC;
      idle(5);
      pins_in = 4'hD;
      idle(15);
      do_read(2'd0); check("glitch_data", readdata, 32'h2);
      do_read(2'd3); check("glitch_edge", readdata, 32'h2);

      // Clear edge, then press completion coincident with a clear of the same bit
      do_write(2'd3, 32'h2);
      check("clr_irq", {31'd0, irq}, 32'd0);
      do_read(2'd3); check("clr_edge", readdata, 32'h0);
      pins_in = 4'hC;
      idle(9);
      do_write(2'd3, 32'h1);
      do_read(2'd3); check("set_wins", readdata, 32'h1);

      // KEY[2] press, clear, release: no release edge
      pins_in = 4'hF;
      idle(12);
      do_write(2'd3, 32'hF);
      pins_in = 4'hB;
      idle(12);
      do_write(2'd3, 32'h4);
      pins_in = 4'hF;
      idle(12);
      do_read(2'd0); check("rel_data", readdata, 32'h0);
      do_read(2'd3); check("rel_edge", readdata, 32'h0);

      // Reset mid-debounce discards the partial press
      pins_in = 4'hE;
      idle(5);
      do_read(2'd3); check("pre_rst_edge", readdata, 32'h0);
      reset = 1'b1;
      model_reset();
      tick();
      reset = 1'b0;
      idle(9);
      do_read(2'd0); check("post_rst_data_old", readdata, 32'h0);
      do_read(2'd0); check("post_rst_data_new", readdata, 32'h1);
      do_read(2'd3); check("post_rst_edge", readdata, 32'h1);

      // Randomized traffic against the model
      for (int c = 0; c < 4000; c++) begin
         if ($urandom_range(15) == 0) pins_in = 4'($urandom);
         if ($urandom_range(3) != 0) begin
            bus(1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom), $urandom);
         end else begin
            bus(1'b0, 1'b0, 1'b0, 2'd0, 32'd0);
         end
         if ($urandom_range(999) == 0) begin
            reset = 1'b1;
            model_reset();
            tick();
            reset = 1'b0;
         end else begin
            tick();
         end
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
